// File: rtl/periph_bus_initiator.sv
// Single-outstanding peripheral-bus initiator: latches an upstream command, issues req/gnt, waits
// for the matching ID response and returns it. Optional abort timeout via PERIPH_INIT_TIMEOUT_EN.
module periph_bus_initiator #(
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned ID_VALUE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic                cmd_wen_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                req_o,
  output logic [31:0]         add_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic                r_opc_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  input  logic [31:0]         r_rdata_i
);

  localparam logic [ID_WIDTH-1:0] IdVal = ID_WIDTH'(ID_VALUE);

  // The abort counter is 8 bits wide, so the threshold must be reachable.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_wen;
  logic        r_req;
  logic        r_wen_o;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic w_rsp_match;
  logic w_timeout;

  assign w_rsp_match = r_valid_i && (r_id_i == IdVal);

`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_cnt;
  // Fires in the cycle the counter steps onto the threshold, so req_o is up TIMEOUT_CYCLES cycles.
  assign w_timeout = ((r_cnt + 8'd1) == TimeoutLimit);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_wen       <= 1'b1;
      r_req       <= 1'b0;
      r_wen_o     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef PERIPH_INIT_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
            r_be    <= cmd_be_i;
            r_wen   <= cmd_wen_i;
            r_req   <= 1'b1;
            r_wen_o <= cmd_wen_i;
            r_state <= StReq;
`ifdef PERIPH_INIT_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        StReq: begin
`ifdef PERIPH_INIT_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
`endif
          if (w_timeout) begin
            r_req       <= 1'b0;
            r_wen_o     <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else if (gnt_i) begin
            r_req   <= 1'b0;
            r_wen_o <= 1'b1;
            r_state <= StWait;
          end
        end
        StWait: begin
`ifdef PERIPH_INIT_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
`endif
          // A matching response beats a timeout landing in the same cycle.
          if (w_rsp_match) begin
            r_rsp_err   <= r_opc_i;
            r_rsp_rdata <= (r_wen && !r_opc_i) ? r_rdata_i : 32'h0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else if (w_timeout) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign req_o       = r_req;
  assign add_o       = r_addr;
  assign wen_o       = r_wen_o;
  assign wdata_o     = r_wdata;
  assign be_o        = r_be;
  assign id_o        = IdVal;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule
